// File: rtl/ddr2_write_control.sv
// MIG UI write sequencer: pulls one upstream word per burst and issues one write
// command plus one write-data beat, with independent command and data handshakes.
//
// state   | meaning
// S_IDLE  | waiting for start with calibration complete
// S_FETCH | wr_data_ready high, waiting for an upstream word
// S_ISSUE | command and/or data beat outstanding on the MIG UI
// S_DONE  | one-cycle done pulse
module ddr2_write_control #(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 128,
    parameter int ADDR_STEP = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic [15:0]         i_burst_count,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_wr_data_valid,
    output logic                o_wr_data_ready,
    output logic                o_busy,
    output logic                o_done,
    input  logic                i_init_calib_complete,
    input  logic                i_app_rdy,
    input  logic                i_app_wdf_rdy,
    output logic                o_app_en,
    output logic [2:0]          o_app_cmd,
    output logic [ADDR_W-1:0]   o_app_addr,
    output logic [DATA_W-1:0]   o_app_wdf_data,
    output logic                o_app_wdf_wren,
    output logic                o_app_wdf_end,
    output logic [DATA_W/8-1:0] o_app_wdf_mask
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_remaining;
    logic                r_cmd_ok;
    logic                r_dat_ok;
    logic                r_done;
    logic                r_app_en;
    logic [ADDR_W-1:0]   r_app_addr;
    logic [DATA_W-1:0]   r_app_wdf_data;
    logic                r_app_wdf_wren;
    logic                r_app_wdf_end;
    logic                w_start_ok;
    logic                w_cmd_acc;
    logic                w_dat_acc;
    logic                w_both_ok;

    assign w_start_ok = i_start & i_init_calib_complete;
    assign w_cmd_acc  = r_app_en & i_app_rdy;
    assign w_dat_acc  = r_app_wdf_wren & i_app_wdf_rdy;
    // A path counts as done if it was accepted earlier or is being accepted now.
    assign w_both_ok  = (r_cmd_ok | w_cmd_acc) & (r_dat_ok | w_dat_acc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = (i_burst_count == 16'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_wr_data_valid) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_both_ok) begin
                    w_state_next = (r_remaining == 16'd1) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr         <= '0;
            r_remaining    <= '0;
            r_cmd_ok       <= 1'b0;
            r_dat_ok       <= 1'b0;
            r_done         <= 1'b0;
            r_app_en       <= 1'b0;
            r_app_addr     <= '0;
            r_app_wdf_data <= '0;
            r_app_wdf_wren <= 1'b0;
            r_app_wdf_end  <= 1'b0;
        end else begin
            r_done <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok && (i_burst_count != 16'd0)) begin
                        r_addr      <= i_base_addr;
                        r_remaining <= i_burst_count;
                    end
                end
                S_FETCH: begin
                    if (i_wr_data_valid) begin
                        r_app_wdf_data <= i_wr_data;
                        r_app_addr     <= r_addr;
                        r_app_en       <= 1'b1;
                        r_app_wdf_wren <= 1'b1;
                        r_app_wdf_end  <= 1'b1;
                        r_cmd_ok       <= 1'b0;
                        r_dat_ok       <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_cmd_acc) begin
                        r_app_en <= 1'b0;
                        r_cmd_ok <= 1'b1;
                    end
                    if (w_dat_acc) begin
                        r_app_wdf_wren <= 1'b0;
                        r_app_wdf_end  <= 1'b0;
                        r_dat_ok       <= 1'b1;
                    end
                    if (w_both_ok) begin
                        r_remaining <= r_remaining - 16'd1;
                        r_addr      <= r_addr + ADDR_W'(ADDR_STEP);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_wr_data_ready = (r_state == S_FETCH);
    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = r_done;
    assign o_app_en        = r_app_en;
    assign o_app_cmd       = 3'b000;
    assign o_app_addr      = r_app_addr;
    assign o_app_wdf_data  = r_app_wdf_data;
    assign o_app_wdf_wren  = r_app_wdf_wren;
    assign o_app_wdf_end   = r_app_wdf_end;
    assign o_app_wdf_mask  = '0;

endmodule
